// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation pipeline.
//   fmt_e        : instruction format code carried with every queue entry
//   OP_*         : base-ISA major opcodes recognised by the decoder
//   F3_*         : funct3 values that select shift-immediate handling
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
//   instr   : raw 32-bit instruction
//   imm     : immediate, sign-extended to XLEN (shift amounts zero-extended)
//   fmt     : decoded format code
//   illegal : opcode not recognised (imm = 0, fmt = NONE)
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm32;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    always_comb begin
        w_imm32 = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                fmt = FMT_I;
                // Shift immediates carry funct7 in the upper bits; only the
                // shamt field is an immediate, and it is unsigned.
                if (w_funct3 == F3_SLLI || w_funct3 == F3_SRXI) begin
                    w_imm32[4:0] = instr[24:20];
                    if (XLEN == 64) w_imm32[5] = instr[25];
                end else begin
                    w_imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt     = FMT_I;
                w_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt     = FMT_S;
                w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt     = FMT_B;
                w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt     = FMT_U;
                w_imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt     = FMT_J;
                w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
            end
            OP_REG: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // All 32-bit forms are already sign-correct; widen by sign extension.
    assign imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with an output FIFO.
//   clk, reset    : clock, synchronous active-high reset
//   flush         : synchronous queue clear (priority over push/pop)
//   in_valid/ready, in_instr, in_tag : instruction input handshake
//   out_valid/ready, out_imm, out_fmt, out_tag, out_illegal : head entry
//   occupancy     : entries currently held
//   illegal_cnt   : saturating count of accepted illegal instructions
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_imm,
    output logic [2:0]                 out_fmt,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                illegal_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [XLEN-1:0]  w_imm;
    fmt_e             w_fmt;
    logic             w_illegal;
    logic             w_push;
    logic             w_pop;

    logic [XLEN-1:0]  r_imm [DEPTH];
    fmt_e             r_fmt [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic             r_ill [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [OW-1:0]    r_occ;
    logic [15:0]      r_cnt;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .imm     (w_imm),
        .fmt     (w_fmt),
        .illegal (w_illegal)
    );

    assign in_ready    = (r_occ < OW'(DEPTH));
    assign out_valid   = (r_occ != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign occupancy   = r_occ;
    assign illegal_cnt = r_cnt;

    // Head fields are masked to zero whenever the queue is empty.
    assign out_imm     = out_valid ? r_imm[r_rd] : '0;
    assign out_fmt     = out_valid ? r_fmt[r_rd] : FMT_NONE;
    assign out_tag     = out_valid ? r_tag[r_rd] : '0;
    assign out_illegal = out_valid ? r_ill[r_rd] : 1'b0;

    // Storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_imm[r_wr] <= w_imm;
            r_fmt[r_wr] <= w_fmt;
            r_tag[r_wr] <= in_tag;
            r_ill[r_wr] <= w_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
                if (w_illegal && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [1:0]  occupancy;
    logic [15:0] illegal_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .occupancy   (occupancy),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the head against the scoreboard on every pop, checks
    // that a stalled head holds, and that an empty queue shows zeros.
    exp_t prev_head;
    bit   prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t cur, e;
        cur = '{imm: out_imm, fmt: out_fmt, tag: out_tag, ill: out_illegal};
        if (!out_valid) begin
            chk("empty_zero", {32'b0, cur}, 64'd0);
        end
        if (prev_stall && out_valid && !reset && !flush)
            chk("stall_hold", {23'b0, cur}, {23'b0, prev_head});
        if (out_valid && out_ready && !reset && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("head", {23'b0, cur}, {23'b0, e});
            end
        end
        prev_head  = cur;
        prev_stall = out_valid && !out_ready && !reset && !flush;
    end

    task automatic push(input logic [31:0] instr, input logic [4:0] tag,
                        input logic [31:0] eimm, input logic [2:0] efmt, input logic eill);
        int unsigned n = 0;
        bit done = 1'b0;
        in_instr = instr;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{imm: eimm, fmt: efmt, tag: tag, ill: eill});
                done = 1'b1;
            end else if (++n > 100) begin
                chk("push_timeout", 64'd1, 64'd0);
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", {31'b0, out_valid, 32'(exp_q.size())}, 64'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned n;
        int unsigned guard;

        repeat (2) step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);

        // Decode vectors, consumer always ready.
        out_ready = 1'b1;
        push(32'hFFF00093, 5'd1, 32'hFFFFFFFF, FMT_I, 1'b0);
        chk("latency1_valid", 64'(out_valid), 64'd1);
        push(32'h40305093, 5'd2, 32'h00000003, FMT_I, 1'b0);
        push(32'h00311093, 5'd3, 32'h00000003, FMT_I, 1'b0);
        push(32'h00112623, 5'd4, 32'h0000000C, FMT_S, 1'b0);
        push(32'hFE000EE3, 5'd5, 32'hFFFFFFFC, FMT_B, 1'b0);
        push(32'h12345037, 5'd6, 32'h12345000, FMT_U, 1'b0);
        push(32'h800000B7, 5'd7, 32'h80000000, FMT_U, 1'b0);
        push(32'h0080006F, 5'd8, 32'h00000008, FMT_J, 1'b0);
        push(32'hFFDFF06F, 5'd9, 32'hFFFFFFFC, FMT_J, 1'b0);
        push(32'h002081B3, 5'd10, 32'h00000000, FMT_R, 1'b0);
        push(32'h00000000, 5'd11, 32'h00000000, FMT_NONE, 1'b1);
        chk("illegal_cnt_inc", 64'(illegal_cnt), 64'd1);
        drain();

        // Backpressure: third push must wait until the consumer drains.
        out_ready = 1'b0;
        push(32'h00100093, 5'd1, 32'h00000001, FMT_I, 1'b0);
        push(32'h00200093, 5'd2, 32'h00000002, FMT_I, 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_occupancy", 64'(occupancy), 64'd2);
        fork
            push(32'h00300093, 5'd3, 32'h00000003, FMT_I, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_held_occ", 64'(occupancy), 64'd2);
                    chk("bp_held_rdy", 64'(in_ready), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush at full with a same-cycle illegal offer.
        out_ready = 1'b0;
        push(32'h00100093, 5'd4, 32'h00000001, FMT_I, 1'b0);
        push(32'h00200093, 5'd5, 32'h00000002, FMT_I, 1'b0);
        in_instr = 32'h0; in_tag = 5'd6; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_full_valid", 64'(out_valid), 64'd0);
        chk("flush_full_occ", 64'(occupancy), 64'd0);
        chk("flush_full_rdy", 64'(in_ready), 64'd1);
        chk("flush_full_cnt", 64'(illegal_cnt), 64'd1);

        // Flush with room left: the accepted-looking push must be dropped.
        push(32'h00100093, 5'd7, 32'h00000001, FMT_I, 1'b0);
        in_instr = 32'h0; in_tag = 5'd8; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        chk("flush_part_valid", 64'(out_valid), 64'd0);
        chk("flush_part_occ", 64'(occupancy), 64'd0);
        chk("flush_part_cnt", 64'(illegal_cnt), 64'd1);

        // Reset mid-stream overrides a same-cycle push.
        push(32'h00100093, 5'd9, 32'h00000001, FMT_I, 1'b0);
        push(32'h00200093, 5'd10, 32'h00000002, FMT_I, 1'b0);
        in_instr = 32'h0; in_valid = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd1);
        chk("mid_rst_cnt", 64'(illegal_cnt), 64'd0);

        // Saturation: stream illegal instructions until the counter tops out.
        out_ready = 1'b1;
        in_instr = 32'h0; in_tag = 5'h1F; in_valid = 1'b1;
        n = 0; guard = 0;
        while (n < 65534 && guard < 140000) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                exp_q.push_back('{imm: 32'h0, fmt: FMT_NONE, tag: 5'h1F, ill: 1'b1});
                n++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stream_count", 64'(n), 64'd65534);
        chk("sat_fffe", 64'(illegal_cnt), 64'hFFFE);
        push(32'h00000000, 5'd12, 32'h0, FMT_NONE, 1'b1);
        chk("sat_ffff", 64'(illegal_cnt), 64'hFFFF);
        push(32'h00000000, 5'd13, 32'h0, FMT_NONE, 1'b1);
        chk("sat_hold", 64'(illegal_cnt), 64'hFFFF);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width (32 or 64 only).
REQ-002 SHALL have parameter DEPTH, default 2, output queue entries (power of two, >=2).
REQ-003 SHALL have parameter TAG_W, default 5, width of the passthrough tag.
REQ-004 SHALL use one clock and a synchronous active-high reset, named and ordered as follows:
  - clk  input  1  rising-edge clock
  - reset  input  1  synchronous, active-high
  - flush  input  1  synchronous queue clear
  - in_valid  input  1  instruction offered
  - in_ready  output  1  instruction accepted when high with in_valid
  - in_instr  input  32  raw instruction
  - in_tag  input  TAG_W  opaque tag, carried unchanged
  - out_valid  output  1  head entry valid
  - out_ready  input  1  consumer takes head
  - out_imm  output  XLEN  sign/zero-extended immediate
  - out_fmt  output  3  format code
  - out_tag  output  TAG_W  tag of head entry
  - out_illegal  output  1  opcode unsupported
  - occupancy  output  $clog2(DEPTH+1)  entries held
  - illegal_cnt  output  16  saturating illegal count

Function
REQ-005 SHALL decode opcode in_instr[6:0] as follows:
  - 0010011, 0000011, 1100111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 0110011 -> R
  - anything else -> NONE, with illegal set
REQ-006 SHALL form immediates per RV base spec, sign-extended from the top immediate bit to XLEN:
  - U: instr[31:12] << 12
  - B: bit 0 = 0
  - J: bit 0 = 0
REQ-007 SHALL, for opcode 0010011 with funct3 001/101, output zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; funct7 bits excluded.
REQ-008 SHALL output imm = 0 for R and NONE formats.
REQ-009 SHALL push the decoded result on the rising edge where in_valid && in_ready; out_valid rises the following cycle when the queue was empty (latency 1).
REQ-010 SHALL drive in_ready = (occupancy < DEPTH), with no full-queue bypass.
REQ-011 SHALL pop on out_valid && out_ready; simultaneous push and pop keeps occupancy unchanged, including at full (in_ready is low at full, so no push occurs).
REQ-012 SHALL deliver entries in FIFO order, with pointer wrap modulo DEPTH.
REQ-013 SHALL hold out_imm, out_fmt, out_tag and out_illegal stable while out_valid && !out_ready.
REQ-014 SHALL, when flush is high, empty the queue at that edge, discard any same-cycle push and pop, and drive out_valid = 0 the next cycle; flush has priority over push and pop.
REQ-015 SHALL increment illegal_cnt on each accepted illegal push, saturating at 0xFFFF; flush does not clear it; a push dropped by flush does not count.
REQ-016 SHALL drive out_imm, out_fmt, out_tag and out_illegal to zero when out_valid is 0.

Reset
REQ-017 SHALL, on reset at a clock edge, set the following, and reset overrides flush and push:
  - occupancy = 0 and both pointers = 0
  - out_valid = 0
  - out_imm, out_fmt, out_tag, out_illegal = 0
  - illegal_cnt = 0
  - in_ready = 1 the next cycle
REQ-018 SHALL, when reset is asserted mid-stream, lose all queued entries with no partial pop.

Structure
REQ-019 SHALL place the following in shared package imm_gen_pkg:
  - fmt_e codes: NONE=0, I=1, S=2, B=3, U=4, J=5, R=6
  - opcode constants
  - funct3 shift constants
REQ-020 SHALL implement decode as combinational sub-module imm_decode (instr in; imm, fmt, illegal out, XLEN parameter), instantiated once ahead of the queue.

Verification
REQ-021 SHALL cover I-type decode: 0xFFF00093 with out_ready=1 -> next cycle out_imm 0xFFFFFFFF, fmt I, illegal 0.
REQ-022 SHALL cover shift-immediate decode: 0x40305093 (srai) -> out_imm 0x00000003.
REQ-023 SHALL cover S- and B-type decode: 0x00112623 (sw) -> 0x0000000C, fmt S; 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt B.
REQ-024 SHALL cover backpressure with DEPTH=2, out_ready=0: push tags 1, 2, 3 ->
  - in_ready low after the 2nd push, occupancy 2, tag 3 held off
  - out_ready=1 -> tags 1, 2, 3 emerge in order, head stable while stalled
REQ-025 SHALL cover illegal handling: 0x00000000 -> out_illegal 1, imm 0, fmt NONE, illegal_cnt +1; when preloaded to 0xFFFF, a further illegal push leaves it at 0xFFFF.
REQ-026 SHALL cover flush: queue full plus in_valid in the same cycle -> next cycle out_valid 0, occupancy 0, in_ready 1, illegal_cnt unchanged.
